// File: rtl/vm_restock_sequencer.sv
// Restock sequencer: queues supplier restock commands and issues them to the
// vending core's supplier port only when the core and consumer side are quiet.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_item/cmd_count/
//   cmd_cost restock console input; flush discards the queue; vm_busy and
//   consumer_act gate issuing; items_s/count_s/cost_s/valid_s drive the core;
//   upd_done/cmd_err pulses and done_cnt/err_cnt saturating counters.
module vm_restock_sequencer #(
    parameter int DEPTH        = 4,
    parameter int QUIET_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_item,
    input  logic [3:0] cmd_count,
    input  logic [7:0] cmd_cost,
    input  logic       flush,
    input  logic       vm_busy,
    input  logic       consumer_act,
    output logic [2:0] items_s,
    output logic [3:0] count_s,
    output logic [7:0] cost_s,
    output logic       valid_s,
    output logic       upd_done,
    output logic       cmd_err,
    output logic [7:0] done_cnt,
    output logic [7:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [14:0]   mem [DEPTH];
    logic [14:0]   head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [3:0]    quiet_cnt;
    logic [3:0]    hold_cnt;
    logic [1:0]    state;
    logic          accept;
    logic          bad_item;
    logic          push;
    logic          pop;
    logic          empty;
    logic          issue_ok;

    assign accept   = cmd_valid && cmd_ready;
    assign bad_item = cmd_item > 3'd5;
    // A push coinciding with flush is dropped along with the queue.
    assign push     = accept && !bad_item && !flush;
    assign empty    = (count == '0);
    assign issue_ok = !empty && (quiet_cnt == 4'(QUIET_CYCLES))
                      && !vm_busy && !consumer_act;
    assign pop      = issue_ok && (state == S_IDLE || state == S_WAIT);
    assign head     = mem[rd_ptr];
    assign upd_done = (state == S_ISSUE) && (hold_cnt == 4'd0);

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else
            count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_item, cmd_count, cmd_cost};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            count     <= count_nxt;
            cmd_ready <= (count_nxt != (AW+1)'(DEPTH));
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quiet_cnt <= '0;
        end else if (vm_busy || consumer_act) begin
            quiet_cnt <= '0;
        end else if (quiet_cnt != 4'(QUIET_CYCLES)) begin
            quiet_cnt <= quiet_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            valid_s  <= 1'b0;
            items_s  <= '0;
            count_s  <= '0;
            cost_s   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_WAIT: begin
                    if (issue_ok) begin
                        state    <= S_ISSUE;
                        valid_s  <= 1'b1;
                        hold_cnt <= 4'(HOLD_CYCLES - 1);
                        {items_s, count_s, cost_s} <= head;
                    end else if (!empty) begin
                        state <= S_WAIT;
                    end
                end
                // The core gives the supplier port priority while idle, so an
                // issue is never aborted once started.
                S_ISSUE: begin
                    if (hold_cnt == 4'd0) begin
                        state   <= S_GAP;
                        valid_s <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    state <= empty ? S_IDLE : S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err  <= 1'b0;
            done_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            cmd_err <= accept && bad_item;
            if (upd_done && done_cnt != 8'hFF)
                done_cnt <= done_cnt + 8'd1;
            if (accept && bad_item && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_vm_restock_sequencer.sv
// Directed bench for vm_restock_sequencer with an issue-order scoreboard.
// A second instance with HOLD_CYCLES=3 covers multi-cycle hold behaviour.
module tb_vm_restock_sequencer;
    typedef struct packed {
        logic [2:0] it;
        logic [3:0] c;
        logic [7:0] co;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_item = '0;
    logic [3:0] cmd_count = '0;
    logic [7:0] cmd_cost = '0;
    logic       flush = 1'b0;
    logic       vm_busy = 1'b0;
    logic       consumer_act = 1'b0;

    logic       cmd_ready, valid_s, upd_done, cmd_err;
    logic [2:0] items_s;
    logic [3:0] count_s;
    logic [7:0] cost_s, done_cnt, err_cnt;

    logic       r3, v3, u3, e3;
    logic [2:0] i3;
    logic [3:0] c3;
    logic [7:0] co3, d3, er3;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_done = 0;
    cmd_t q[$];

    always #5 clk = ~clk;

    vm_restock_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_item(cmd_item), .cmd_count(cmd_count), .cmd_cost(cmd_cost),
        .flush(flush), .vm_busy(vm_busy), .consumer_act(consumer_act),
        .items_s(items_s), .count_s(count_s), .cost_s(cost_s),
        .valid_s(valid_s), .upd_done(upd_done), .cmd_err(cmd_err),
        .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    vm_restock_sequencer #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(r3),
        .cmd_item(cmd_item), .cmd_count(cmd_count), .cmd_cost(cmd_cost),
        .flush(flush), .vm_busy(vm_busy), .consumer_act(consumer_act),
        .items_s(i3), .count_s(c3), .cost_s(co3),
        .valid_s(v3), .upd_done(u3), .cmd_err(e3),
        .done_cnt(d3), .err_cnt(er3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] it, input logic [3:0] c,
                            input logic [7:0] co);
        check("ready_before_push", cmd_ready, 1);
        cmd_item  = it;
        cmd_count = c;
        cmd_cost  = co;
        cmd_valid = 1'b1;
        if (it <= 3'd5)
            q.push_back('{it, c, co});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30; i++) begin
            if (valid_s) break;
            tick();
        end
        check("wait_valid", valid_s, 1);
    endtask

    // Scoreboard: every rising valid_s must match the oldest queued command.
    int run = 0;
    int gap = 0;
    bit seen = 0;
    always @(negedge clk) begin
        if (rst) begin
            run  = 0;
            gap  = 0;
            seen = 0;
        end else if (valid_s) begin
            run++;
            check("hold_len", run, 1);
            check("upd_done_in_issue", upd_done, 1);
            if (run == 1) begin
                if (seen)
                    check("low_gap_ge2", gap >= 2, 1);
                check("issue_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    cmd_t e;
                    e = q.pop_front();
                    check("items_s", items_s, e.it);
                    check("count_s", count_s, e.c);
                    check("cost_s", cost_s, e.co);
                end
            end
        end else begin
            if (run > 0) begin
                seen = 1;
                gap  = 0;
            end
            run = 0;
            if (gap < 100) gap++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_valid", valid_s, 0);
        check("rst_done", done_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_upd", upd_done, 0);

        // 1: single command, quiet window of 2 before issue
        rst = 1'b0;
        push_cmd(3'd2, 4'd7, 8'd75);
        check("t1_e1_valid", valid_s, 0);
        tick();
        check("t1_e2_valid", valid_s, 0);
        tick();
        check("t1_e3_valid", valid_s, 1);
        check("t1_items", items_s, 2);
        check("t1_count", count_s, 7);
        check("t1_cost", cost_s, 75);
        check("t1_upd", upd_done, 1);
        tick();
        check("t1_e4_valid", valid_s, 0);
        check("t1_upd_low", upd_done, 0);
        check("t1_fields_held", items_s, 2);
        exp_done = 1;
        check("t1_done", done_cnt, exp_done);

        // 2: fill FIFO while busy, then drain in order
        vm_busy = 1'b1;
        tick();
        push_cmd(3'd0, 4'd1, 8'd10);
        push_cmd(3'd1, 4'd2, 8'd20);
        push_cmd(3'd3, 4'd3, 8'd30);
        push_cmd(3'd4, 4'd4, 8'd40);
        check("t2_full_ready", cmd_ready, 0);
        cmd_item  = 3'd5;
        cmd_count = 4'd5;
        cmd_cost  = 8'd50;
        cmd_valid = 1'b1;
        q.push_back('{3'd5, 4'd5, 8'd50});
        tick();
        tick();
        check("t2_busy_no_valid", valid_s, 0);
        vm_busy = 1'b0;
        begin
            bit ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    ok = 1;
                    break;
                end
            end
            check("t2_fifth_accept", ok, 1);
            tick();
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !valid_s) break;
            tick();
        end
        check("t2_drained", q.size(), 0);
        tick();
        tick();
        exp_done = 6;
        check("t2_done", done_cnt, exp_done);

        // 3: out-of-range item rejected
        push_cmd(3'd6, 4'd9, 8'd99);
        check("t3_err_pulse", cmd_err, 1);
        tick();
        check("t3_err_low", cmd_err, 0);
        check("t3_err_cnt", err_cnt, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t3_no_valid", valid_s, 0);
        check("t3_ready", cmd_ready, 1);

        // 4a: toggling consumer activity starves issue
        consumer_act = 1'b1;
        push_cmd(3'd1, 4'd6, 8'd66);
        for (int i = 0; i < 11; i++) begin
            consumer_act = (i % 2 == 0);
            tick();
            check("t4_starved", valid_s, 0);
        end
        consumer_act = 1'b0;
        tick();
        check("t4_q1", valid_s, 0);
        tick();
        check("t4_q2", valid_s, 0);
        tick();
        check("t4_issue", valid_s, 1);
        tick();
        exp_done = 7;
        check("t4_done", done_cnt, exp_done);

        // 4b: HOLD_CYCLES=3 instance ignores consumer/busy during issue
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        push_cmd(3'd3, 4'd8, 8'd123);
        tick();
        tick();
        check("t4b_v3_1", v3, 1);
        check("t4b_u3_1", u3, 0);
        check("t4b_i3", i3, 3);
        check("t4b_c3", c3, 8);
        check("t4b_co3", co3, 123);
        consumer_act = 1'b1;
        vm_busy = 1'b1;
        tick();
        check("t4b_v3_2", v3, 1);
        check("t4b_u3_2", u3, 0);
        tick();
        check("t4b_v3_3", v3, 1);
        check("t4b_u3_3", u3, 1);
        tick();
        check("t4b_v3_off", v3, 0);
        check("t4b_d3", d3, 1);
        consumer_act = 1'b0;
        vm_busy = 1'b0;
        exp_done = 1;
        check("t4b_done", done_cnt, exp_done);

        // 5: flush with a simultaneous push
        vm_busy = 1'b1;
        push_cmd(3'd0, 4'd1, 8'd1);
        push_cmd(3'd1, 4'd2, 8'd2);
        push_cmd(3'd2, 4'd3, 8'd3);
        flush = 1'b1;
        cmd_item  = 3'd4;
        cmd_count = 4'd4;
        cmd_cost  = 8'd4;
        cmd_valid = 1'b1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        q.delete();
        check("t5_ready", cmd_ready, 1);
        vm_busy = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t5_no_valid", valid_s, 0);
        check("t5_done_same", done_cnt, exp_done);
        // flush during an issue
        vm_busy = 1'b1;
        push_cmd(3'd5, 4'd15, 8'd200);
        push_cmd(3'd4, 4'd14, 8'd201);
        vm_busy = 1'b0;
        wait_valid();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_q_left", q.size(), 1);
        q.delete();
        for (int i = 0; i < 6; i++) tick();
        exp_done = 2;
        check("t5_issue_done", done_cnt, exp_done);
        check("t5_valid_low", valid_s, 0);

        // 6: asynchronous reset in mid-issue
        push_cmd(3'd2, 4'd2, 8'd22);
        wait_valid();
        rst = 1'b1;
        q.delete();
        #1;
        check("t6_valid_drop", valid_s, 0);
        check("t6_v3_drop", v3, 0);
        tick();
        rst = 1'b0;
        check("t6_ready", cmd_ready, 1);
        check("t6_done", done_cnt, 0);
        check("t6_err", err_cnt, 0);
        check("t6_d3", d3, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t6_empty_no_valid", valid_s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
